// File: rtl/clock_pkg.sv
// Shared types and field widths for the clock/alarm blocks in the clk_1Hz domain.
package clock_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SET     = 2'd1,
        RINGING = 2'd2,
        SNOOZE  = 2'd3
    } state_t;

    localparam int HOUR_MAX = 23;
    localparam int MIN_MAX  = 59;
    localparam int SEC_W    = 6;
    localparam int MIN_W    = 6;
    localparam int HOUR_W   = 5;

endpackage

// File: rtl/mod_wrap_inc.sv
// Increment-by-one with wrap to zero once MAX is reached.
module mod_wrap_inc #(
    parameter int W   = 6,
    parameter int MAX = 59
) (
    input  logic [W-1:0] value,
    output logic [W-1:0] next_value
);

    assign next_value = (value == W'(MAX)) ? '0 : value + 1'b1;

endmodule

// File: rtl/alarm_controller.sv
// Alarm time storage, match detection and ring/snooze/stop sequencing for the 24-hour clock.
// Handshakes: all button inputs are single-cycle pulses, acted on at the edge where they are high.
module alarm_controller
    import clock_pkg::*;
#(
    parameter int RING_TIMEOUT = 60,
    parameter int SNOOZE_SEC   = 300,
    parameter int MAX_SNOOZE   = 3,
    parameter int ALARM_H_RST  = 6,
    parameter int ALARM_M_RST  = 0
) (
    input  logic              clk_1Hz,
    input  logic              reset,
    input  logic [SEC_W-1:0]  seconds,
    input  logic [MIN_W-1:0]  minutes,
    input  logic [HOUR_W-1:0] hours,
    input  logic              alarm_enable,
    input  logic              btn_set,
    input  logic              btn_inc_h,
    input  logic              btn_inc_m,
    input  logic              btn_stop,
    input  logic              btn_snooze,
    output logic [HOUR_W-1:0] alarm_hours,
    output logic [MIN_W-1:0]  alarm_minutes,
    output logic [HOUR_W-1:0] edit_hours,
    output logic [MIN_W-1:0]  edit_minutes,
    output logic              buzzer,
    output logic              snooze_active,
    output logic              set_mode,
    output state_t            fsm_state
);

    localparam int RING_W = $clog2(RING_TIMEOUT + 1);
    localparam int SNZ_W  = $clog2(SNOOZE_SEC + 1);
    localparam int NUM_W  = $clog2(MAX_SNOOZE + 1);

    state_t              state, state_n;
    logic [RING_W-1:0]   ring_cnt, ring_cnt_n;
    logic [SNZ_W-1:0]    snz_cnt, snz_cnt_n;
    logic [NUM_W-1:0]    snz_num, snz_num_n;
    logic [HOUR_W-1:0]   alarm_hours_n, edit_hours_n, edit_hours_inc;
    logic [MIN_W-1:0]    alarm_minutes_n, edit_minutes_n, edit_minutes_inc;
    logic                match;

    mod_wrap_inc #(.W(HOUR_W), .MAX(HOUR_MAX)) u_inc_h (
        .value      (edit_hours),
        .next_value (edit_hours_inc)
    );

    mod_wrap_inc #(.W(MIN_W), .MAX(MIN_MAX)) u_inc_m (
        .value      (edit_minutes),
        .next_value (edit_minutes_inc)
    );

    // seconds==0 limits the match to one edge per minute
    assign match = alarm_enable && (hours == alarm_hours) &&
                   (minutes == alarm_minutes) && (seconds == '0);

    assign fsm_state = state;

    always_comb begin
        state_n         = state;
        ring_cnt_n      = ring_cnt;
        snz_cnt_n       = snz_cnt;
        snz_num_n       = snz_num;
        alarm_hours_n   = alarm_hours;
        alarm_minutes_n = alarm_minutes;
        edit_hours_n    = edit_hours;
        edit_minutes_n  = edit_minutes;
        case (state)
            IDLE: begin
                if (btn_set) begin
                    state_n        = SET;
                    edit_hours_n   = alarm_hours;
                    edit_minutes_n = alarm_minutes;
                end else if (match) begin
                    state_n    = RINGING;
                    ring_cnt_n = '0;
                    snz_num_n  = '0;
                end
            end
            SET: begin
                if (btn_stop) begin
                    state_n = IDLE;
                end else if (btn_set) begin
                    state_n         = IDLE;
                    alarm_hours_n   = edit_hours;
                    alarm_minutes_n = edit_minutes;
                end else begin
                    if (btn_inc_h) edit_hours_n = edit_hours_inc;
                    if (btn_inc_m) edit_minutes_n = edit_minutes_inc;
                end
            end
            RINGING: begin
                ring_cnt_n = ring_cnt + 1'b1;
                if (!alarm_enable || btn_stop) begin
                    state_n = IDLE;
                end else if (btn_snooze && (snz_num < NUM_W'(MAX_SNOOZE))) begin
                    state_n   = SNOOZE;
                    snz_cnt_n = SNZ_W'(SNOOZE_SEC - 1);
                    snz_num_n = snz_num + 1'b1;
                end else if (btn_snooze) begin
                    state_n = IDLE;
                end else if (ring_cnt == RING_W'(RING_TIMEOUT - 1)) begin
                    state_n = IDLE;
                end
            end
            SNOOZE: begin
                if (!alarm_enable || btn_stop) begin
                    state_n = IDLE;
                end else if (snz_cnt == '0) begin
                    state_n    = RINGING;
                    ring_cnt_n = '0;
                end else begin
                    snz_cnt_n = snz_cnt - 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_1Hz or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            ring_cnt      <= '0;
            snz_cnt       <= '0;
            snz_num       <= '0;
            alarm_hours   <= HOUR_W'(ALARM_H_RST);
            alarm_minutes <= MIN_W'(ALARM_M_RST);
            edit_hours    <= HOUR_W'(ALARM_H_RST);
            edit_minutes  <= MIN_W'(ALARM_M_RST);
            buzzer        <= 1'b0;
            snooze_active <= 1'b0;
            set_mode      <= 1'b0;
        end else begin
            state         <= state_n;
            ring_cnt      <= ring_cnt_n;
            snz_cnt       <= snz_cnt_n;
            snz_num       <= snz_num_n;
            alarm_hours   <= alarm_hours_n;
            alarm_minutes <= alarm_minutes_n;
            edit_hours    <= edit_hours_n;
            edit_minutes  <= edit_minutes_n;
            buzzer        <= (state_n == RINGING);
            snooze_active <= (state_n == SNOOZE);
            set_mode      <= (state_n == SET);
        end
    end

endmodule

// File: tb/tb_alarm_controller.sv
// Directed bench for alarm_controller: ring, timeout, snooze limit, set/cancel, enable and reset cases.
module tb_alarm_controller;
    import clock_pkg::*;

    logic        clk_1Hz = 1'b0;
    logic        reset;
    logic [5:0]  seconds, minutes;
    logic [4:0]  hours;
    logic        alarm_enable, btn_set, btn_inc_h, btn_inc_m, btn_stop, btn_snooze;
    logic [4:0]  alarm_hours, edit_hours;
    logic [5:0]  alarm_minutes, edit_minutes;
    logic        buzzer, snooze_active, set_mode;
    state_t      fsm_state;

    int checks = 0;
    int errors = 0;

    alarm_controller dut (
        .clk_1Hz       (clk_1Hz),
        .reset         (reset),
        .seconds       (seconds),
        .minutes       (minutes),
        .hours         (hours),
        .alarm_enable  (alarm_enable),
        .btn_set       (btn_set),
        .btn_inc_h     (btn_inc_h),
        .btn_inc_m     (btn_inc_m),
        .btn_stop      (btn_stop),
        .btn_snooze    (btn_snooze),
        .alarm_hours   (alarm_hours),
        .alarm_minutes (alarm_minutes),
        .edit_hours    (edit_hours),
        .edit_minutes  (edit_minutes),
        .buzzer        (buzzer),
        .snooze_active (snooze_active),
        .set_mode      (set_mode),
        .fsm_state     (fsm_state)
    );

    always #5 clk_1Hz = ~clk_1Hz;

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_1Hz);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_time(input int h, input int m, input int s);
        hours   = 5'(h);
        minutes = 6'(m);
        seconds = 6'(s);
    endtask

    initial begin
        reset = 1'b1;
        alarm_enable = 1'b1;
        btn_set = 0; btn_inc_h = 0; btn_inc_m = 0; btn_stop = 0; btn_snooze = 0;
        set_time(12, 0, 1);
        #3;
        check("rst_buzzer", buzzer, 0);
        check("rst_snooze", snooze_active, 0);
        check("rst_set_mode", set_mode, 0);
        check("rst_alarm_h", alarm_hours, 6);
        check("rst_alarm_m", alarm_minutes, 0);
        check("rst_edit_h", edit_hours, 6);
        check("rst_edit_m", edit_minutes, 0);
        check("rst_state", 32'(fsm_state), 32'(IDLE));
        tick();
        reset = 1'b0;

        // Match edge and the second before it
        set_time(5, 59, 59); tick();
        check("pre_match_buzzer", buzzer, 0);
        set_time(6, 0, 0); tick();
        check("match_buzzer", buzzer, 1);
        check("match_state", 32'(fsm_state), 32'(RINGING));
        set_time(6, 0, 1);

        // Timeout: 60 cycles of ringing in total
        tick(59);
        check("ring_cycle60_buzzer", buzzer, 1);
        tick();
        check("timeout_buzzer", buzzer, 0);
        check("timeout_state", 32'(fsm_state), 32'(IDLE));

        // Snooze three times, fourth press stops
        set_time(6, 0, 0); tick();
        check("ring2_buzzer", buzzer, 1);
        set_time(6, 0, 1);
        tick(4);
        for (int k = 1; k <= 3; k++) begin
            btn_snooze = 1'b1; tick(); btn_snooze = 1'b0;
            check($sformatf("snooze%0d_active", k), snooze_active, 1);
            check($sformatf("snooze%0d_buzzer", k), buzzer, 0);
            tick(299);
            check($sformatf("snooze%0d_299_buzzer", k), buzzer, 0);
            tick();
            check($sformatf("snooze%0d_resume_buzzer", k), buzzer, 1);
            check($sformatf("snooze%0d_resume_active", k), snooze_active, 0);
        end
        btn_snooze = 1'b1; tick(); btn_snooze = 1'b0;
        check("snooze4_buzzer", buzzer, 0);
        check("snooze4_active", snooze_active, 0);
        check("snooze4_state", 32'(fsm_state), 32'(IDLE));

        // Set session with overlapping hour/minute increments, then commit
        btn_set = 1'b1; tick(); btn_set = 1'b0;
        check("set_mode_on", set_mode, 1);
        check("set_edit_h_load", edit_hours, 6);
        for (int i = 0; i < 61; i++) begin
            btn_inc_m = 1'b1;
            btn_inc_h = (i < 20);
            tick();
        end
        btn_inc_m = 1'b0; btn_inc_h = 1'b0;
        check("edit_h_wrapped", edit_hours, 2);
        check("edit_m_wrapped", edit_minutes, 1);
        btn_set = 1'b1; tick(); btn_set = 1'b0;
        check("commit_alarm_h", alarm_hours, 2);
        check("commit_alarm_m", alarm_minutes, 1);
        check("commit_set_mode", set_mode, 0);

        // Second session: match ignored in SET, set+stop together cancels
        btn_set = 1'b1; tick(); btn_set = 1'b0;
        check("set2_edit_load_m", edit_minutes, 1);
        btn_inc_h = 1'b1; btn_inc_m = 1'b1; tick(3);
        btn_inc_h = 1'b0; btn_inc_m = 1'b0;
        check("set2_edit_h", edit_hours, 5);
        check("set2_edit_m", edit_minutes, 4);
        set_time(2, 1, 0); tick();
        check("set_ignores_match", buzzer, 0);
        check("set_ignores_match_state", 32'(fsm_state), 32'(SET));
        set_time(2, 1, 1);
        btn_set = 1'b1; btn_stop = 1'b1; tick(); btn_set = 1'b0; btn_stop = 1'b0;
        check("cancel_alarm_h", alarm_hours, 2);
        check("cancel_alarm_m", alarm_minutes, 1);
        check("cancel_state", 32'(fsm_state), 32'(IDLE));

        // Disabled match, then enable drop while ringing
        alarm_enable = 1'b0;
        set_time(2, 1, 0); tick();
        check("disabled_no_ring", buzzer, 0);
        alarm_enable = 1'b1; tick();
        check("enabled_ring", buzzer, 1);
        set_time(2, 1, 1);
        alarm_enable = 1'b0; tick();
        check("enable_drop_buzzer", buzzer, 0);
        check("enable_drop_state", 32'(fsm_state), 32'(IDLE));
        alarm_enable = 1'b1;

        // btn_set beats a match on the same edge
        set_time(2, 1, 0);
        btn_set = 1'b1; tick(); btn_set = 1'b0;
        check("set_prio_state", 32'(fsm_state), 32'(SET));
        check("set_prio_buzzer", buzzer, 0);
        set_time(2, 1, 1);
        btn_stop = 1'b1; tick(); btn_stop = 1'b0;

        // Asynchronous reset during SNOOZE
        set_time(2, 1, 0); tick();
        set_time(2, 1, 1);
        btn_snooze = 1'b1; tick(); btn_snooze = 1'b0;
        check("pre_reset_snooze", snooze_active, 1);
        #2 reset = 1'b1;
        #1;
        check("async_rst_snooze", snooze_active, 0);
        check("async_rst_alarm_h", alarm_hours, 6);
        check("async_rst_alarm_m", alarm_minutes, 0);
        check("async_rst_state", 32'(fsm_state), 32'(IDLE));
        tick();
        reset = 1'b0;
        tick(301);
        check("no_ring_after_reset", buzzer, 0);
        check("no_ring_after_reset_state", 32'(fsm_state), 32'(IDLE));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
